// File: rtl/gbvga_pkg.sv
// Shared constants and vertical scan states for the Game Boy to VGA framebuffer path.
package gbvga_pkg;

    localparam int GB_W      = 160;
    localparam int GB_H      = 144;
    localparam int GB_PIXELS = GB_W * GB_H;
    localparam int VGA_H_PIX = 640;
    localparam int VGA_V_PIX = 480;

    typedef enum logic [1:0] {
        V_TOP  = 2'd0,
        V_ACT  = 2'd1,
        V_DONE = 2'd2
    } vstate_t;

endpackage

// File: rtl/toggle_sync.sv
// Two-flop synchroniser for a level toggled in another clock domain; every
// edge of the toggle becomes a one-cycle pulse in the local domain.
module toggle_sync (
    input  logic clk,
    input  logic reset,
    input  logic tgl_i,
    output logic pulse_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], tgl_i};
            prev_q <= sync_q[1];
        end
    end

    assign pulse_o = sync_q[1] ^ prev_q;

endmodule

// File: rtl/fb_scan_sequencer.sv
// Framebuffer read sequencer: maps the VGA beam onto an integer-scaled, centred
// 160x144 window using counters only, and owns the display/write bank swap.
module fb_scan_sequencer
    import gbvga_pkg::*;
#(
    parameter int SCALE  = 3,
    parameter int X0     = (VGA_H_PIX - GB_W * SCALE) / 2,
    parameter int Y0     = (VGA_V_PIX - GB_H * SCALE) / 2,
    parameter int RD_LAT = 1
) (
    input  logic        CLK_25MHz,
    input  logic        reset,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        frame_start,
    input  logic        gb_frame_tgl,
    output logic [15:0] fb_raddr,
    output logic        wr_bank,
    output logic        pix_en,
    output logic [7:0]  drop_cnt
);

    localparam logic [9:0]  H_LOAD    = 10'(X0 - 1);
    localparam logic [9:0]  V_LOAD    = 10'(Y0 - 1);
    localparam logic [9:0]  H_LAST    = 10'(VGA_H_PIX - 1);
    localparam logic [1:0]  SUB_LAST  = 2'(SCALE - 1);
    localparam logic [7:0]  GX_LAST   = 8'(GB_W - 1);
    localparam logic [7:0]  GY_LAST   = 8'(GB_H - 1);
    localparam logic [14:0] LINE_STEP = 15'(GB_W);

    vstate_t       state_q, state_d;
    logic          line_end, v_load, v_step, h_load;
    logic [7:0]    gy_q, gx_q;
    logic [1:0]    ysub_q, xsub_q;
    logic [14:0]   line_base_q, pix_idx;
    logic          h_act_q;
    logic [RD_LAT:0] pix_pipe_q;
    logic          gb_done;
    logic          wr_bank_q, wr_bank_d;
    logic          ready_q, ready_d;
    logic [7:0]    drop_q, drop_d;
    logic [15:0]   raddr_q;

    assign line_end = (hpos == H_LAST);

    always_ff @(posedge CLK_25MHz) begin
        if (reset) state_q <= V_TOP;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = V_TOP;
        end else if (line_end) begin
            case (state_q)
                V_TOP:   if (vpos == V_LOAD) state_d = V_ACT;
                V_ACT:   if (gy_q == GY_LAST && ysub_q == SUB_LAST) state_d = V_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        v_load = 1'b0;
        v_step = 1'b0;
        h_load = 1'b0;
        if (!frame_start) begin
            case (state_q)
                V_TOP: v_load = line_end && (vpos == V_LOAD);
                V_ACT: begin
                    v_step = line_end;
                    h_load = (hpos == H_LOAD);
                end
                default: ;
            endcase
        end
    end

    // line_base tracks gy*160 so the pixel index needs only an adder
    always_ff @(posedge CLK_25MHz) begin
        if (reset || frame_start || v_load) begin
            gy_q        <= '0;
            ysub_q      <= '0;
            line_base_q <= '0;
        end else if (v_step) begin
            if (ysub_q == SUB_LAST) begin
                ysub_q      <= '0;
                gy_q        <= gy_q + 8'd1;
                line_base_q <= line_base_q + LINE_STEP;
            end else begin
                ysub_q <= ysub_q + 2'd1;
            end
        end
    end

    always_ff @(posedge CLK_25MHz) begin
        if (reset || frame_start) begin
            h_act_q <= 1'b0;
            gx_q    <= '0;
            xsub_q  <= '0;
        end else if (h_load) begin
            h_act_q <= 1'b1;
            gx_q    <= '0;
            xsub_q  <= '0;
        end else if (h_act_q) begin
            if (xsub_q == SUB_LAST) begin
                xsub_q <= '0;
                if (gx_q == GX_LAST) h_act_q <= 1'b0;
                else                 gx_q    <= gx_q + 8'd1;
            end else begin
                xsub_q <= xsub_q + 2'd1;
            end
        end
    end

    assign pix_idx = line_base_q + 15'(gx_q);

    always_ff @(posedge CLK_25MHz) begin
        if (reset) begin
            raddr_q    <= '0;
            pix_pipe_q <= '0;
        end else begin
            if (h_act_q) raddr_q <= {~wr_bank_q, pix_idx};
            pix_pipe_q <= {pix_pipe_q[RD_LAT-1:0], h_act_q};
        end
    end

    toggle_sync u_gb_sync (
        .clk     (CLK_25MHz),
        .reset   (reset),
        .tgl_i   (gb_frame_tgl),
        .pulse_o (gb_done)
    );

    // A frame finishing on the frame_start cycle is shown at once; if one was
    // already waiting, the older one is shown and the new one stays pending.
    always_comb begin
        wr_bank_d = wr_bank_q;
        ready_d   = ready_q;
        drop_d    = drop_q;
        if (frame_start) begin
            if (ready_q || gb_done) wr_bank_d = ~wr_bank_q;
            ready_d = ready_q && gb_done;
        end else if (gb_done) begin
            ready_d = 1'b1;
            if (ready_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge CLK_25MHz) begin
        if (reset) begin
            wr_bank_q <= 1'b1;
            ready_q   <= 1'b0;
            drop_q    <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            ready_q   <= ready_d;
            drop_q    <= drop_d;
        end
    end

    assign fb_raddr = raddr_q;
    assign wr_bank  = wr_bank_q;
    assign pix_en   = pix_pipe_q[RD_LAT];
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_fb_scan_sequencer.sv
// Bench for fb_scan_sequencer at SCALE=3 and SCALE=2 side by side, driven by a
// compressed beam: rows of interest are scanned in full, others only at hpos 0 and 639.
module tb_fb_scan_sequencer;

    logic        CLK_25MHz = 1'b0;
    logic        reset;
    logic [9:0]  hpos, vpos;
    logic        frame_start, gb_frame_tgl;
    logic [15:0] raddr3, raddr2;
    logic        wr3, wr2, pix3, pix2;
    logic [7:0]  drop3, drop2;

    always #20 CLK_25MHz = ~CLK_25MHz;

    fb_scan_sequencer #(.SCALE(3)) dut3 (
        .CLK_25MHz    (CLK_25MHz),
        .reset        (reset),
        .hpos         (hpos),
        .vpos         (vpos),
        .frame_start  (frame_start),
        .gb_frame_tgl (gb_frame_tgl),
        .fb_raddr     (raddr3),
        .wr_bank      (wr3),
        .pix_en       (pix3),
        .drop_cnt     (drop3)
    );

    fb_scan_sequencer #(.SCALE(2)) dut2 (
        .CLK_25MHz    (CLK_25MHz),
        .reset        (reset),
        .hpos         (hpos),
        .vpos         (vpos),
        .frame_start  (frame_start),
        .gb_frame_tgl (gb_frame_tgl),
        .fb_raddr     (raddr2),
        .wr_bank      (wr2),
        .pix_en       (pix2),
        .drop_cnt     (drop2)
    );

    typedef struct {
        int unsigned addr;
        int          h;
        int          v;
    } exp_t;

    exp_t        q3[$];
    exp_t        q2[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          sb_on       = 1'b0;
    bit          frame_valid = 1'b0;
    bit          exp_bank    = 1'b0;
    logic [15:0] prev3 = '0;
    logic [15:0] prev2 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit in_win(input int s, input int h, input int v);
        int x0, y0;
        x0 = (640 - 160 * s) / 2;
        y0 = (480 - 144 * s) / 2;
        return (h >= x0) && (h < x0 + 160 * s) && (v >= y0) && (v < y0 + 144 * s);
    endfunction

    function automatic int unsigned exp_addr(input int s, input int h, input int v, input bit bank);
        int x0, y0;
        x0 = (640 - 160 * s) / 2;
        y0 = (480 - 144 * s) / 2;
        return (int'(bank) << 15) + ((v - y0) / s) * 160 + (h - x0) / s;
    endfunction

    // Drive one beam cycle; window pixels are expected on pix_en two cycles later.
    task automatic cyc(input int h, input int v, input bit r);
        hpos        = 10'(h);
        vpos        = 10'(v);
        frame_start = (h == 0 && v == 0);
        reset       = r;
        if (r) begin
            frame_valid = 1'b0;
            while (q3.size() > 0 && q3[$].v == v && q3[$].h > h) void'(q3.pop_back());
            while (q2.size() > 0 && q2[$].v == v && q2[$].h > h) void'(q2.pop_back());
        end else begin
            if (h == 0 && v == 0) frame_valid = 1'b1;
            if (frame_valid && in_win(3, h, v)) q3.push_back('{exp_addr(3, h, v, exp_bank), h + 2, v});
            if (frame_valid && in_win(2, h, v)) q2.push_back('{exp_addr(2, h, v, exp_bank), h + 2, v});
        end
        @(posedge CLK_25MHz);
        #1;
    endtask

    always @(negedge CLK_25MHz) begin
        bit   due;
        exp_t e;
        if (sb_on) begin
            due = q3.size() > 0 && q3[0].h == int'(hpos) && q3[0].v == int'(vpos);
            chk("pix_en_s3", {31'd0, pix3}, {31'd0, due});
            if (due) begin
                e = q3.pop_front();
                chk("raddr_s3", {16'd0, prev3}, e.addr);
            end
            due = q2.size() > 0 && q2[0].h == int'(hpos) && q2[0].v == int'(vpos);
            chk("pix_en_s2", {31'd0, pix2}, {31'd0, due});
            if (due) begin
                e = q2.pop_front();
                chk("raddr_s2", {16'd0, prev2}, e.addr);
            end
        end
        prev3 = raddr3;
        prev2 = raddr2;
    end

    function automatic bit full_row(input int fno, input int v);
        case (v)
            24, 25, 26, 27, 96: return 1'b1;
            97, 98, 383, 455:   return fno == 1;
            200:                return fno == 1 || fno == 4;
            default:            return 1'b0;
        endcase
    endfunction

    function automatic bit tgl_here(input int fno, input int v);
        return (fno == 1 && v == 300) ||
               (fno == 2 && (v == 100 || v == 110 || v == 120)) ||
               (fno == 3 && v == 524) ||
               (fno == 4 && v == 100);
    endfunction

    task automatic post(input int fno, input int v, input int h);
        if (fno == 1 && v == 455 && h == 559) chk("last_addr_s3", {16'd0, raddr3}, 23039);
        if (fno == 1 && v == 383 && h == 479) chk("last_addr_s2", {16'd0, raddr2}, 23039);
        if (fno == 1 && v == 310 && h == 0)   chk("wr_bank_mid", {31'd0, wr3}, 1);
        if (fno == 1 && v == 524 && h == 639) chk("wr_bank_hold", {31'd0, wr3}, 1);
        if (fno == 2 && v == 0 && h == 0) begin
            chk("wr_bank_swap1_s3", {31'd0, wr3}, 0);
            chk("wr_bank_swap1_s2", {31'd0, wr2}, 0);
        end
        if (fno == 2 && v == 24 && h == 100)  chk("raddr_bank1", {31'd0, raddr3[15]}, 1);
        if (fno == 2 && v == 150 && h == 0)   chk("drop_mid", {24'd0, drop3}, 2);
        if (fno == 3 && v == 0 && h == 0) begin
            chk("drop_after3", {24'd0, drop3}, 2);
            chk("drop_after3_s2", {24'd0, drop2}, 2);
            chk("wr_bank_swap2", {31'd0, wr3}, 1);
        end
        if (fno == 4 && v == 0 && h == 0) begin
            chk("wr_bank_coinc", {31'd0, wr3}, 0);
            chk("drop_coinc", {24'd0, drop3}, 2);
        end
        if (fno == 4 && v == 150 && h == 0)   chk("drop_ready_clr", {24'd0, drop3}, 2);
        if (fno == 4 && v == 200 && h == 300) begin
            chk("rst_mid_raddr_s3", {16'd0, raddr3}, 0);
            chk("rst_mid_pix_s3", {31'd0, pix3}, 0);
            chk("rst_mid_raddr_s2", {16'd0, raddr2}, 0);
            chk("rst_mid_pix_s2", {31'd0, pix2}, 0);
            chk("rst_mid_wr_bank", {31'd0, wr3}, 1);
            chk("rst_mid_drop", {24'd0, drop3}, 0);
        end
    endtask

    task automatic run_frame(input int fno);
        bit full;
        bit r;
        for (int v = 0; v < 525; v++) begin
            full = full_row(fno, v);
            for (int h = 0; h < 640; h++) begin
                if (full || h == 0 || h == 639) begin
                    if (h == 0 && v == 0) exp_bank = (fno % 2 == 0);
                    if (h == 0 && tgl_here(fno, v)) gb_frame_tgl = ~gb_frame_tgl;
                    r = (fno == 4 && v == 200 && h == 300);
                    cyc(h, v, r);
                    post(fno, v, h);
                end
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        hpos         = '0;
        vpos         = '0;
        frame_start  = 1'b0;
        gb_frame_tgl = 1'b0;
        for (int i = 0; i < 4; i++) cyc(639, 524, 1'b1);
        sb_on = 1'b1;
        chk("rst_raddr", {16'd0, raddr3}, 0);
        chk("rst_wr_bank", {31'd0, wr3}, 1);
        chk("rst_pix_en", {31'd0, pix3}, 0);
        chk("rst_drop", {24'd0, drop3}, 0);
        chk("rst_wr_bank_s2", {31'd0, wr2}, 1);
        for (int f = 1; f <= 5; f++) run_frame(f);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
